// File: rtl/mult_share_arbiter_pkg.sv
// Package mult_arb_pkg: shared types and constants for the shared-multiplier arbiter.
//   state_e     FSM encoding {IDLE, MUL, OUT, RESP}. OUT is only reachable when
//               MULT_ARB_OUTREG_EN is defined.
//   DEF_N/DEF_W default requester count and operand width.
//   clog2_min1  id width for a requester count, never less than 1 bit.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    OUT  = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam int DEF_N = 4;
  localparam int DEF_W = 4;

  // Width of a requester index; a 1-bit field is kept even when N <= 2.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester/response bundle of mult_share_arbiter.
//   req_valid[N]   per-requester operand valid
//   req_ready[N]   one-hot accept from the arbiter
//   req_x/req_y    packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready/rsp_data/rsp_id  tagged product return channel
// Modports: slave = arbiter side, master = requester/consumer side.
interface mult_share_arbiter_if
  import mult_arb_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) ();

  localparam int IDW = clog2_min1(N);

  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_x;
  logic [N*W-1:0] req_y;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [2*W-1:0] rsp_data;
  logic [IDW-1:0] rsp_id;

  modport slave (
    input  req_valid, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport master (
    output req_valid, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/mult_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req[N]         request vector
//   ptr            highest-priority index this cycle
//   gnt_onehot[N]  one-hot winner (zero when nothing requests)
//   gnt_idx        winner index
//   any            at least one request present
// The request vector is rotated so ptr lands on bit 0, priority-encoded, and
// the offset is rotated back by adding ptr modulo N.
module rr_pick
  import mult_arb_pkg::*;
#(
  parameter  int N   = DEF_N,
  localparam int IDW = clog2_min1(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt_onehot,
  output logic [IDW-1:0] gnt_idx,
  output logic           any
);

  localparam int SW = IDW + 1;

  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;
  logic [IDW-1:0] off_s;
  logic [SW-1:0]  sum_s;

  // Rotate, priority-encode the lowest set bit, rotate the offset back.
  always_comb begin
    dbl_s = {req, req};
    rot_s = dbl_s[ptr +: N];
    off_s = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      off_s = rot_s[i] ? IDW'(i) : off_s;
    end
    sum_s = {1'b0, ptr} + {1'b0, off_s};
    if (sum_s >= SW'(N)) begin
      gnt_idx = IDW'(sum_s - SW'(N));
    end else begin
      gnt_idx = sum_s[IDW-1:0];
    end
    any = |req;
    if (any) begin
      gnt_onehot = N'(1) << gnt_idx;
    end else begin
      gnt_onehot = '0;
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: time-shares one external combinational WxW multiplier
// among N requesters with round-robin arbitration.
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   bus (slave)  requester valid/ready/operands and tagged response channel
//   mul_x/mul_y  registered operands to the shared multiplier
//   mul_o        combinational product back from the multiplier
//   busy         high whenever the FSM is not IDLE
// Build option MULT_ARB_OUTREG_EN: adds an OUT state with a product register
// (prod_q) between the multiplier and rsp_data, costing one cycle of latency.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_share_arbiter_if.slave  bus,
  output logic [W-1:0]         mul_x,
  output logic [W-1:0]         mul_y,
  input  logic [2*W-1:0]       mul_o,
  output logic                 busy
);

  localparam int IDW = clog2_min1(N);

  state_e         state_r;
  state_e         state_nxt_s;
  logic [IDW-1:0] ptr_r;
  logic [IDW-1:0] id_q_r;
  logic [W-1:0]   mul_x_r;
  logic [W-1:0]   mul_y_r;
  logic [2*W-1:0] rsp_data_r;
  logic [IDW-1:0] rsp_id_r;
  logic [N-1:0]   gnt_onehot_s;
  logic [IDW-1:0] gnt_idx_s;
  logic           any_s;
  logic           accept_s;
`ifdef MULT_ARB_OUTREG_EN
  logic [2*W-1:0] prod_q_r;
`endif

  rr_pick #(.N(N)) u_rr_pick (
    .req        (bus.req_valid),
    .ptr        (ptr_r),
    .gnt_onehot (gnt_onehot_s),
    .gnt_idx    (gnt_idx_s),
    .any        (any_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; an accept happens only out of IDLE.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          accept_s    = 1'b1;
          state_nxt_s = MUL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
`ifdef MULT_ARB_OUTREG_EN
      MUL:  state_nxt_s = OUT;
`else
      MUL:  state_nxt_s = RESP;
`endif
      OUT:  state_nxt_s = RESP;
      RESP: begin
        // Completing a handshake returns to IDLE; the next grant is a cycle later.
        if (bus.rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand capture, pointer advance and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r      <= '0;
      id_q_r     <= '0;
      mul_x_r    <= '0;
      mul_y_r    <= '0;
      rsp_data_r <= '0;
      rsp_id_r   <= '0;
`ifdef MULT_ARB_OUTREG_EN
      prod_q_r   <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mul_x_r <= bus.req_x[gnt_idx_s*W +: W];
            mul_y_r <= bus.req_y[gnt_idx_s*W +: W];
            id_q_r  <= gnt_idx_s;
            if (gnt_idx_s == IDW'(N - 1)) begin
              ptr_r <= '0;
            end else begin
              ptr_r <= gnt_idx_s + IDW'(1);
            end
          end
        end
        MUL: begin
`ifdef MULT_ARB_OUTREG_EN
          prod_q_r   <= mul_o;
`else
          rsp_data_r <= mul_o;
          rsp_id_r   <= id_q_r;
`endif
        end
        OUT: begin
`ifdef MULT_ARB_OUTREG_EN
          rsp_data_r <= prod_q_r;
          rsp_id_r   <= id_q_r;
`endif
        end
        default: begin
        end
      endcase
    end
  end

  // Grant is shown only in IDLE and is forced low while reset is applied.
  assign bus.req_ready = (state_r == IDLE && !rst) ? gnt_onehot_s : '0;
  assign bus.rsp_valid = (state_r == RESP);
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_id    = rsp_id_r;
  assign mul_x         = mul_x_r;
  assign mul_y         = mul_y_r;
  assign busy          = (state_r != IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: directed vector table plus
// hand-written sequences (mid-op reset, rotation, backpressure, fairness)
// and a randomized run against an x*y / round-robin reference.
module tb_mult_share_arbiter;
  import mult_arb_pkg::*;

  localparam int N   = 4;
  localparam int W   = 4;
  localparam int IDW = clog2_min1(N);
`ifdef MULT_ARB_OUTREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    int             id;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] prod;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   mul_x;
  logic [W-1:0]   mul_y;
  logic [2*W-1:0] mul_o;
  logic           busy;
  int             checks   = 0;
  int             failures = 0;
  vec_t           vecs[10];

  mult_share_arbiter_if #(.N(N), .W(W)) bus ();

  mult_share_arbiter #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .mul_x (mul_x),
    .mul_y (mul_y),
    .mul_o (mul_o),
    .busy  (busy)
  );

  // Stand-in for the shared WxW multiplier.
  assign mul_o = {{W{1'b0}}, mul_x} * {{W{1'b0}}, mul_y};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int id, input logic [W-1:0] x, input logic [W-1:0] y);
    bus.req_x[id*W +: W] = x;
    bus.req_y[id*W +: W] = y;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_rsp(input string nm);
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
  endtask

  // One isolated request with latency, sampling and release checks.
  task automatic single_op(input string nm, input int id, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [2*W-1:0] exp);
    logic [N-1:0] oh;
    oh = N'(1) << id;
    set_op(id, x, y);
    bus.req_valid = oh;
    #1;
    chk({nm, "_req_ready"}, 32'(bus.req_ready), 32'(oh));
    chk({nm, "_busy_idle"}, 32'(busy), 32'd0);
    tick();
    bus.req_valid = '0;
    set_op(id, ~x, ~y);
    chk({nm, "_mul_x"}, 32'(mul_x), 32'(x));
    chk({nm, "_mul_y"}, 32'(mul_y), 32'(y));
    chk({nm, "_ready_low"}, 32'(bus.req_ready), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    chk({nm, "_early_valid"}, 32'(bus.rsp_valid), 32'd0);
    for (int c = 1; c < LAT - 1; c++) begin
      tick();
      chk({nm, "_early_valid"}, 32'(bus.rsp_valid), 32'd0);
    end
    tick();
    chk({nm, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({nm, "_rsp_data"}, 32'(bus.rsp_data), 32'(exp));
    chk({nm, "_rsp_id"}, 32'(bus.rsp_id), 32'(id));
    tick();
    chk({nm, "_valid_clr"}, 32'(bus.rsp_valid), 32'd0);
    chk({nm, "_busy_clr"}, 32'(busy), 32'd0);
  endtask

  // One op with a caller-held req_valid mask; expects a given winner.
  task automatic held_op(input string nm, input int exp_id, input logic [2*W-1:0] exp_prod);
    logic [N-1:0] oh;
    oh = N'(1) << exp_id;
    #1;
    chk({nm, "_busy_idle"}, 32'(busy), 32'd0);
    chk({nm, "_grant"}, 32'(bus.req_ready), 32'(oh));
    tick();
    wait_rsp(nm);
    chk({nm, "_rsp_id"}, 32'(bus.rsp_id), 32'(exp_id));
    chk({nm, "_rsp_data"}, 32'(bus.rsp_data), 32'(exp_prod));
    tick();
  endtask

  initial begin
    logic [W-1:0]   ox[N];
    logic [W-1:0]   oy[N];
    logic [N-1:0]   mask;
    logic [2*W-1:0] exp_p;
    int             model_ptr;
    int             g;
    int             n;
    logic           done;

    vecs[0] = '{2, 4'd15, 4'd15, 8'hE1};
    vecs[1] = '{0, 4'd0,  4'd9,  8'd0};
    vecs[2] = '{1, 4'd1,  4'd15, 8'd15};
    vecs[3] = '{3, 4'd8,  4'd8,  8'd64};
    vecs[4] = '{0, 4'd3,  4'd3,  8'd9};
    vecs[5] = '{1, 4'd6,  4'd6,  8'd36};
    vecs[6] = '{2, 4'd9,  4'd9,  8'd81};
    vecs[7] = '{3, 4'd12, 4'd12, 8'd144};
    vecs[8] = '{1, 4'd7,  4'd11, 8'd77};
    vecs[9] = '{3, 4'd5,  4'd13, 8'd65};

    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.rsp_ready = 1'b1;
    #1;
    // Reset state while rst is held.
    bus.req_valid = 4'b1111;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_mul_x", 32'(mul_x), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    do_reset();

    // Reset asserted while the FSM is in MUL.
    set_op(1, 4'd5, 4'd5);
    bus.req_valid = 4'b0010;
    tick();
    chk("midrst_busy_before", 32'(busy), 32'd1);
    chk("midrst_mul_x_before", 32'(mul_x), 32'd5);
    rst = 1'b1;
    #1;
    chk("midrst_mul_x", 32'(mul_x), 32'd0);
    chk("midrst_mul_y", 32'(mul_y), 32'd0);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("midrst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("midrst_rsp_id", 32'(bus.rsp_id), 32'd0);
    tick();
    tick();
    bus.req_valid = '0;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end

    // All requesters held valid: rotation starts at 0 after reset.
    for (int i = 0; i < N; i++) set_op(i, W'((i + 1) * 3), W'((i + 1) * 3));
    bus.req_valid = 4'b1111;
    held_op("rot0", 0, 8'd9);
    held_op("rot1", 1, 8'd36);
    held_op("rot2", 2, 8'd81);
    held_op("rot3", 3, 8'd144);
    held_op("rot4", 0, 8'd9);
    bus.req_valid = '0;
    tick();

    // Directed vector table, including operand corners.
    for (int v = 0; v < 10; v++) begin
      single_op($sformatf("vec%0d", v), vecs[v].id, vecs[v].x, vecs[v].y, vecs[v].prod);
    end

    // Backpressure: response held for 5 cycles while others request.
    set_op(1, 4'd10, 4'd11);
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    wait_rsp("bp");
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_data", 32'(bus.rsp_data), 32'h6E);
      chk("bp_id", 32'(bus.rsp_id), 32'd1);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
    chk("bp_release_busy", 32'(busy), 32'd0);

    // Fairness from ptr=3 (set by a grant to requester 2).
    single_op("fair_setup", 2, 4'd2, 4'd3, 8'd6);
    set_op(0, 4'd4, 4'd5);
    set_op(2, 4'd7, 4'd7);
    bus.req_valid = 4'b0101;
    held_op("fair0", 0, 8'd20);
    held_op("fair1", 2, 8'd49);
    held_op("fair2", 0, 8'd20);
    held_op("fair3", 2, 8'd49);
    bus.req_valid = '0;
    tick();

    // Randomized ops against a reference product and round-robin model.
    do_reset();
    model_ptr = 0;
    for (int op = 0; op < 1000; op++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        ox[i] = W'($urandom);
        oy[i] = W'($urandom);
        set_op(i, ox[i], oy[i]);
      end
      bus.req_valid = mask;
      g = -1;
      for (int k = N - 1; k >= 0; k--) begin
        if (mask[(model_ptr + k) % N]) g = (model_ptr + k) % N;
      end
      exp_p = {{W{1'b0}}, ox[g]} * {{W{1'b0}}, oy[g]};
      #1;
      chk("rnd_grant", 32'(bus.req_ready), 32'(N'(1) << g));
      tick();
      bus.req_valid = '0;
      model_ptr = (g + 1) % N;
      done = 1'b0;
      n = 0;
      while (!done && n < 40) begin
        bus.rsp_ready = 1'($urandom_range(0, 1));
        #1;
        if (bus.rsp_valid && bus.rsp_ready) begin
          chk("rnd_data", 32'(bus.rsp_data), 32'(exp_p));
          chk("rnd_id", 32'(bus.rsp_id), 32'(g));
          done = 1'b1;
        end
        tick();
        n++;
      end
      chk("rnd_completed", 32'(done), 32'd1);
      bus.rsp_ready = 1'b1;
      chk("rnd_idle", 32'(busy), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
